// File: rtl/oflow_cr_pkg.sv
// Shared definitions for the conflict-resolve stage: LUT/flag memory
// geometry and the frame sequencer state encoding.
package oflow_cr_pkg;

    localparam int ADDR_WIDTH_LUT = 11;
    localparam int DATA_WIDTH_LUT = 16;
    localparam int FLAG_WIDTH     = 2;

    // Fixed encodings so the state value stays stable for debug visibility.
    typedef enum logic [2:0] {
        ST_INIT_CLR = 3'd0,
        ST_IDLE     = 3'd1,
        ST_START    = 3'd2,
        ST_RUN      = 3'd3,
        ST_ABORT    = 3'd4,
        ST_CLR      = 3'd5,
        ST_REPORT   = 3'd6
    } cr_ctrl_state_t;

endpackage

// File: rtl/oflow_cr_frame_ctrl_if.sv
// Bundle between the frame sequencer, the CR FSM and the shared LUT/flag
// memory write port. The master side is the frame sequencer.
interface oflow_cr_frame_ctrl_if #(
    parameter int ADDR_WIDTH_LUT = oflow_cr_pkg::ADDR_WIDTH_LUT,
    parameter int DATA_WIDTH_LUT = oflow_cr_pkg::DATA_WIDTH_LUT,
    parameter int FLAG_WIDTH     = oflow_cr_pkg::FLAG_WIDTH
);

    // CR FSM handshake
    logic                      start_cr;
    logic                      done_cr;
    logic                      conflict_counter_th;
    logic                      cr_reset_N;

    // CR FSM memory requests
    logic [ADDR_WIDTH_LUT-1:0] cr_address_lut;
    logic [DATA_WIDTH_LUT-1:0] cr_data_in_lut;
    logic                      cr_we_lut;
    logic [FLAG_WIDTH-1:0]     cr_data_in_flag;

    // Shared memory write port
    logic [ADDR_WIDTH_LUT-1:0] lut_address;
    logic [DATA_WIDTH_LUT-1:0] lut_data_in;
    logic                      lut_we;
    logic [FLAG_WIDTH-1:0]     flag_data_in;
    logic                      flag_we;

    modport master (
        output start_cr, cr_reset_N,
        output lut_address, lut_data_in, lut_we, flag_data_in, flag_we,
        input  done_cr, conflict_counter_th,
        input  cr_address_lut, cr_data_in_lut, cr_we_lut, cr_data_in_flag
    );

    modport slave (
        input  start_cr, cr_reset_N,
        input  lut_address, lut_data_in, lut_we, flag_data_in, flag_we,
        output done_cr, conflict_counter_th,
        output cr_address_lut, cr_data_in_lut, cr_we_lut, cr_data_in_flag
    );

endinterface

// File: rtl/oflow_lut_clear_sweeper.sv
// Address generator for the LUT/flag zeroing sweep. While start is held
// the address advances once per cycle; done flags the last address so
// the owner can leave the sweep. The counter wraps back to zero on its
// own, so every sweep begins at address 0.
module oflow_lut_clear_sweeper #(
    parameter int ADDR_WIDTH = oflow_cr_pkg::ADDR_WIDTH_LUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  we,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic [ADDR_WIDTH-1:0] clr_addr_d;

    // Advance the sweep address only while the sweep is enabled.
    always_comb begin
        clr_addr_d = clr_addr_q;
        if (start) begin
            clr_addr_d = clr_addr_q + ADDR_ONE;
        end else begin
            clr_addr_d = clr_addr_q;
        end
    end

    // Sweep address register; reset restarts any sweep from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_addr_q <= '0;
        end else begin
            clr_addr_q <= clr_addr_d;
        end
    end

    assign address = clr_addr_q;
    assign we      = start;
    assign done    = start && (clr_addr_q == ADDR_LAST);

endmodule

// File: rtl/oflow_cr_frame_ctrl.sv
// Per-frame sequencer for the conflict-resolve stage. Launches the CR FSM,
// guards it with a run-cycle watchdog, owns the LUT/flag write port
// (CR pass-through during RUN, zeroing sweep otherwise) and reports
// per-frame status.
module oflow_cr_frame_ctrl #(
    parameter int ADDR_WIDTH_LUT = 11,
    parameter int DATA_WIDTH_LUT = 16,
    parameter int FLAG_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CYC_CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    output logic                     ready,
    output logic                     frame_done,
    output logic                     status_th,
    output logic                     status_timeout,
    output logic [CYC_CNT_WIDTH-1:0] run_cycles,
    oflow_cr_frame_ctrl_if.master    cr_bus
);

    import oflow_cr_pkg::*;

    localparam logic [CYC_CNT_WIDTH-1:0] CYC_ONE      = {{(CYC_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CYC_CNT_WIDTH-1:0] CYC_MAX      = {CYC_CNT_WIDTH{1'b1}};
    localparam logic [CYC_CNT_WIDTH-1:0] TIMEOUT_LAST = CYC_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    cr_ctrl_state_t             state_q;
    cr_ctrl_state_t             state_d;
    logic                       status_th_q;
    logic                       status_th_d;
    logic                       status_timeout_q;
    logic                       status_timeout_d;
    logic [CYC_CNT_WIDTH-1:0]   run_cycles_q;
    logic [CYC_CNT_WIDTH-1:0]   run_cycles_d;

    logic                       sweep_en;
    logic [ADDR_WIDTH_LUT-1:0]  sweep_addr;
    logic                       sweep_we;
    logic                       sweep_done;

    logic                       ready_c;
    logic                       frame_done_c;
    logic                       start_cr_c;
    logic                       cr_reset_n_c;
    logic [ADDR_WIDTH_LUT-1:0]  lut_address_c;
    logic [DATA_WIDTH_LUT-1:0]  lut_data_in_c;
    logic                       lut_we_c;
    logic [FLAG_WIDTH-1:0]      flag_data_in_c;
    logic                       flag_we_c;

    // One sweeper serves both the power-up clear and the per-frame clear.
    assign sweep_en = (state_q == ST_INIT_CLR) || (state_q == ST_CLR);

    oflow_lut_clear_sweeper #(
        .ADDR_WIDTH (ADDR_WIDTH_LUT)
    ) u_sweeper (
        .clk     (clk),
        .reset   (reset),
        .start   (sweep_en),
        .address (sweep_addr),
        .we      (sweep_we),
        .done    (sweep_done)
    );

    // Next-state, watchdog and status latching.
    always_comb begin
        state_d          = state_q;
        status_th_d      = status_th_q;
        status_timeout_d = status_timeout_q;
        run_cycles_d     = run_cycles_q;
        case (state_q)
            ST_INIT_CLR: begin
                if (sweep_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT_CLR;
                end
            end
            ST_IDLE: begin
                if (frame_start) begin
                    state_d          = ST_START;
                    status_th_d      = 1'b0;
                    status_timeout_d = 1'b0;
                    run_cycles_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (run_cycles_q != CYC_MAX) begin
                    run_cycles_d = run_cycles_q + CYC_ONE;
                end else begin
                    run_cycles_d = run_cycles_q;
                end
                // A completion in the same cycle as the watchdog expiry wins.
                if (cr_bus.done_cr) begin
                    status_th_d = cr_bus.conflict_counter_th;
                    state_d     = ST_CLR;
                end else if (run_cycles_q == TIMEOUT_LAST) begin
                    status_timeout_d = 1'b1;
                    state_d          = ST_ABORT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ABORT: begin
                state_d = ST_CLR;
            end
            ST_CLR: begin
                if (sweep_done) begin
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_CLR;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT_CLR;
            end
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_INIT_CLR;
            status_th_q      <= 1'b0;
            status_timeout_q <= 1'b0;
            run_cycles_q     <= '0;
        end else begin
            state_q          <= state_d;
            status_th_q      <= status_th_d;
            status_timeout_q <= status_timeout_d;
            run_cycles_q     <= run_cycles_d;
        end
    end

    // State-decoded handshake outputs and memory write-port mux.
    always_comb begin
        ready_c        = 1'b0;
        frame_done_c   = 1'b0;
        start_cr_c     = 1'b0;
        cr_reset_n_c   = 1'b1;
        lut_address_c  = '0;
        lut_data_in_c  = '0;
        lut_we_c       = 1'b0;
        flag_data_in_c = '0;
        flag_we_c      = 1'b0;
        if (reset) begin
            cr_reset_n_c = 1'b0;
        end else begin
            case (state_q)
                ST_INIT_CLR, ST_CLR: begin
                    lut_address_c = sweep_addr;
                    lut_we_c      = sweep_we;
                    flag_we_c     = sweep_we;
                end
                ST_IDLE: begin
                    ready_c = 1'b1;
                end
                ST_START: begin
                    start_cr_c = 1'b1;
                end
                ST_RUN: begin
                    lut_address_c  = cr_bus.cr_address_lut;
                    lut_data_in_c  = cr_bus.cr_data_in_lut;
                    lut_we_c       = cr_bus.cr_we_lut;
                    flag_data_in_c = cr_bus.cr_data_in_flag;
                    flag_we_c      = cr_bus.cr_we_lut;
                end
                ST_ABORT: begin
                    cr_reset_n_c = 1'b0;
                end
                ST_REPORT: begin
                    frame_done_c = 1'b1;
                end
                default: begin
                    cr_reset_n_c = 1'b1;
                end
            endcase
        end
    end

    assign ready               = ready_c;
    assign frame_done          = frame_done_c;
    assign status_th           = status_th_q;
    assign status_timeout      = status_timeout_q;
    assign run_cycles          = run_cycles_q;
    assign cr_bus.start_cr     = start_cr_c;
    assign cr_bus.cr_reset_N   = cr_reset_n_c;
    assign cr_bus.lut_address  = lut_address_c;
    assign cr_bus.lut_data_in  = lut_data_in_c;
    assign cr_bus.lut_we       = lut_we_c;
    assign cr_bus.flag_data_in = flag_data_in_c;
    assign cr_bus.flag_we      = flag_we_c;

endmodule

// File: doc/oflow_cr_frame_ctrl.md
Name: oflow_cr_frame_ctrl

Overview:
- Per-frame sequencer for the conflict-resolve stage.
- Launches the conflict-resolve FSM (start_cr/done_cr handshake) and supervises it with a cycle watchdog.
- Owns the shared LUT/flag memory write port: passes the CR FSM through while CR runs, otherwise drives a zeroing sweep so every frame starts with an empty LUT.
- Reports per-frame status to the core control.

Parameters:
- ADDR_WIDTH_LUT, 11, LUT/flag address width; LUT depth = 1<<ADDR_WIDTH_LUT.
- DATA_WIDTH_LUT, 16, LUT word width.
- FLAG_WIDTH, 2, flag memory word width.
- TIMEOUT_CYCLES, 4096, maximum cycles allowed in RUN before abort.
- CYC_CNT_WIDTH, 16, width of the run-cycle counter (saturating).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  request to process one frame; accepted only when ready=1.
- ready  out  1  high in IDLE only.
- frame_done  out  1  one-cycle pulse at frame end.
- status_th  out  1  frame hit the conflict threshold; valid while frame_done=1, held until next accept.
- status_timeout  out  1  watchdog abort; same timing as status_th.
- run_cycles  out  CYC_CNT_WIDTH  cycles spent in RUN for the last frame; held until next accept.
- start_cr  out  1  start pulse to the CR FSM.
- done_cr  in  1  done from the CR FSM.
- conflict_counter_th  in  1  threshold flag from the CR FSM, sampled with done_cr.
- cr_reset_N  out  1  active-low reset to the CR FSM.
- cr_address_lut  in  ADDR_WIDTH_LUT  CR FSM address.
- cr_data_in_lut  in  DATA_WIDTH_LUT  CR FSM LUT write data.
- cr_we_lut  in  1  CR FSM write enable; also qualifies flag writes.
- cr_data_in_flag  in  FLAG_WIDTH  CR FSM flag write data.
- lut_address  out  ADDR_WIDTH_LUT  memory address; also drives the flag address.
- lut_data_in  out  DATA_WIDTH_LUT  memory LUT write data.
- lut_we  out  1  LUT write enable.
- flag_data_in  out  FLAG_WIDTH  flag write data.
- flag_we  out  1  flag write enable.

Behaviour:
- States: INIT_CLR, IDLE, START, RUN, ABORT, CLR, REPORT. The state register is synchronous. All outputs except the status registers are decoded combinationally from state.
- Reset (any cycle, including mid-sweep or mid-RUN): next state INIT_CLR, clr_addr=0, status_th=0, status_timeout=0, run_cycles=0, cr_reset_N=0 while reset=1.
- Reset values of the combinational outputs: start_cr=0, frame_done=0, ready=0.
- INIT_CLR / CLR:
  - lut_we=flag_we=1, lut_address=clr_addr, data outputs all zero.
  - clr_addr increments every cycle.
  - At clr_addr=DEPTH-1 the write is performed, clr_addr wraps to 0, and the next state is IDLE (from INIT_CLR) or REPORT (from CLR).
  - A sweep lasts exactly DEPTH cycles.
- IDLE: ready=1, memory writes off. frame_start=1 moves to START and clears status_th, status_timeout and run_cycles.
- START: start_cr=1 for exactly one cycle, then RUN.
- RUN:
  - Memory outputs are a combinational pass-through of the cr_* inputs. flag_we=cr_we_lut.
  - run_cycles increments and saturates at all-ones.
  - done_cr=1: latch status_th=conflict_counter_th, go to CLR.
  - Otherwise, when run_cycles reaches TIMEOUT_CYCLES-1: status_timeout=1, go to ABORT.
  - If done_cr and the timeout coincide, done_cr wins and status_timeout stays 0.
- ABORT: cr_reset_N=0 for one cycle, writes off, then CLR.
- REPORT: frame_done=1 for one cycle, then IDLE.
- frame_start outside IDLE is ignored and is not queued.
- done_cr outside RUN is ignored.
- cr_reset_N=1 in every state except ABORT and during reset.
- Throughput: accept to frame_done = 1 (START) + RUN length + DEPTH (CLR) + 1 cycles. ready returns one cycle after frame_done.

Decomposition:
- Shared package oflow_cr_pkg holds:
  - state enum cr_ctrl_state_t;
  - LUT/flag width constants (DATA_WIDTH_LUT, ADDR_WIDTH_LUT, FLAG_WIDTH), so the CR FSM and this block use one definition.
- One natural sub-module: oflow_lut_clear_sweeper.
  - Inputs: start, clk, reset. Outputs: address, we, done.
  - This block instantiates it once and reuses it for both INIT_CLR and CLR.
  - The write-port mux and the watchdog stay in the top block.

Test Plan:
- Reset released, no activity -> lut_we=1 for exactly 2048 consecutive cycles, addresses 0..2047 with zero data; ready=1 on the next cycle.
- frame_start, then done_cr 10 cycles after start_cr with conflict_counter_th=0 -> start_cr is a single pulse; memory outputs mirror cr_* during RUN; 2048-cycle clear; frame_done pulse; run_cycles=10; status_th=0.
- Same as above with conflict_counter_th=1 -> status_th=1 at frame_done and held through IDLE until the next accept.
- done_cr never asserted, TIMEOUT_CYCLES=64 -> after 64 RUN cycles cr_reset_N low for one cycle, then clear sweep, then frame_done with status_timeout=1 and status_th=0.
- done_cr in the same cycle the timeout fires -> status_timeout=0, no ABORT, normal CLR.
- frame_start pulsed during RUN and CLR, and reset asserted at clear address 1000 -> extra starts ignored; after reset, a full 2048-cycle INIT_CLR from address 0, then ready=1.
